registrador_tabuleiro: RTL

- Parametrised board register for the tic-tac-toe datapath. It stores X and O occupancy as two N_CELLS-bit vectors.
- It accepts one move per cycle and rejects illegal moves with a 1-cycle error pulse.
- It keeps a LIFO history of moves so the last move can be undone.
- Sits between the game control unit (write/undo strobes) and the win-detection / display logic (board vectors).

---
 rtl/tabuleiro_pkg.sv | 24 ++
 rtl/pilha_jogadas.sv | 52 +++++
 rtl/registrador_tabuleiro.sv | 103 ++++++++++
 3 files changed

// File: rtl/tabuleiro_pkg.sv
// Shared definitions for the tic-tac-toe board register: player encoding,
// board-size presets and the per-cycle action decoded from the control strobes.
package tabuleiro_pkg;

    localparam logic JOGADOR_X = 1'b0;
    localparam logic JOGADOR_O = 1'b1;

    localparam int N_CELLS_3X3 = 9;
    localparam int ADDR_W_3X3  = 4;
    localparam int N_CELLS_4X4 = 16;
    localparam int ADDR_W_4X4  = 4;

    typedef enum logic [1:0] {
        ACAO_NADA,
        ACAO_JOGADA,
        ACAO_DESFAZ,
        ACAO_ERRO
    } acao_t;

    function automatic int largura_contador(input int n_cells);
        return $clog2(n_cells + 1);
    endfunction

endpackage

// File: rtl/pilha_jogadas.sv
// Move-history LIFO: one address pushed per accepted move, popped on undo.
// topo is the most recent address, or 0 when the stack is empty.
module pilha_jogadas
    import tabuleiro_pkg::*;
#(
    parameter  int DEPTH = N_CELLS_3X3,
    parameter  int WIDTH = ADDR_W_3X3,
    localparam int CNT_W = largura_contador(DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] topo,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: non-blocking assignments for every register so all state updates see the pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
            // NOTE: the history is cleared with everything else, so after clear the block is all-zero, not just logically empty.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && (count != '0)) begin
            count <= count - 1'b1;
        end else if (push && (32'(count) < DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count == CNT_W'(i)) begin
                    mem[i] <= din;
                end
            end
            count <= count + 1'b1;
        end
    end

    // Loop-select instead of mem[count-1] keeps the index width independent of DEPTH.
    always_comb begin
        // NOTE: default assignment first so no path through the loop leaves topo unassigned (no latch).
        topo = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(count) == i + 1) begin
                topo = mem[i];
            end
        end
    end

endmodule

// File: rtl/registrador_tabuleiro.sv
// Board register: X/O occupancy vectors, move legality check, undo via the
// move-history stack, and registered one-cycle accept/reject pulses.
module registrador_tabuleiro
    import tabuleiro_pkg::*;
#(
    parameter  int N_CELLS = N_CELLS_3X3,
    parameter  int ADDR_W  = ADDR_W_3X3,
    localparam int CNT_W   = largura_contador(N_CELLS)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               enable,
    input  logic               desfaz,
    input  logic [ADDR_W-1:0]  endereco,
    input  logic               jogador,
    output logic [N_CELLS-1:0] tabuleiro_x,
    output logic [N_CELLS-1:0] tabuleiro_o,
    output logic [CNT_W-1:0]   num_jogadas,
    output logic [ADDR_W-1:0]  ultimo_endereco,
    output logic               cheio,
    output logic               jogada_ok,
    output logic               erro
);

    logic [N_CELLS-1:0] mascara_end;
    logic [N_CELLS-1:0] mascara_ult;
    logic [N_CELLS-1:0] ocupacao;
    logic               endereco_valido;
    logic               celula_livre;
    logic               jogada_legal;
    logic               empilha;
    logic               desempilha;
    acao_t              acao;

    // One-hot masks; an out-of-range address yields an all-zero mask.
    always_comb begin
        mascara_end = '0;
        mascara_ult = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            mascara_end[i] = (32'(endereco) == i);
            mascara_ult[i] = (32'(ultimo_endereco) == i);
        end
    end

    assign ocupacao        = tabuleiro_x | tabuleiro_o;
    assign endereco_valido = (32'(endereco) < N_CELLS);
    assign celula_livre    = ((mascara_end & ocupacao) == '0);
    assign cheio           = (32'(num_jogadas) == N_CELLS);
    assign jogada_legal    = endereco_valido && celula_livre && !cheio;

    // Undo wins over a simultaneous move; the move is then dropped silently.
    always_comb begin
        acao = ACAO_NADA;
        if (desfaz) begin
            acao = (num_jogadas != '0) ? ACAO_DESFAZ : ACAO_ERRO;
        end else if (enable) begin
            acao = jogada_legal ? ACAO_JOGADA : ACAO_ERRO;
        end
    end

    assign empilha    = !clear && (acao == ACAO_JOGADA);
    assign desempilha = !clear && (acao == ACAO_DESFAZ);

    pilha_jogadas #(
        .DEPTH (N_CELLS),
        .WIDTH (ADDR_W)
    ) u_pilha (
        .clock (clock),
        .clear (clear),
        .push  (empilha),
        .pop   (desempilha),
        .din   (endereco),
        .topo  (ultimo_endereco),
        .count (num_jogadas)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            tabuleiro_x <= '0;
            tabuleiro_o <= '0;
            jogada_ok   <= 1'b0;
            erro        <= 1'b0;
        end else begin
            jogada_ok <= (acao == ACAO_JOGADA) || (acao == ACAO_DESFAZ);
            erro      <= (acao == ACAO_ERRO);
            case (acao)
                ACAO_JOGADA: begin
                    if (jogador == JOGADOR_O) begin
                        tabuleiro_o <= tabuleiro_o | mascara_end;
                    end else begin
                        tabuleiro_x <= tabuleiro_x | mascara_end;
                    end
                end
                ACAO_DESFAZ: begin
                    tabuleiro_x <= tabuleiro_x & ~mascara_ult;
                    tabuleiro_o <= tabuleiro_o & ~mascara_ult;
                end
                default: ;
            endcase
        end
    end

endmodule
